// File: rtl/io_map_pkg.sv
// io_map_pkg
//   Shared definitions for the push-button MMIO peripheral: the default base
//   address of its 2-word register window, the register offsets, the STATUS
//   bit positions and the debounce FSM state type.
package io_map_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0400;

  // Register offsets inside the window; only addr[2] distinguishes them.
  localparam logic [2:0] OFF_STATUS = 3'h0;
  localparam logic [2:0] OFF_COUNT  = 3'h4;

  // STATUS register bit positions.
  localparam int STAT_PENDING = 0;
  localparam int STAT_LEVEL   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_IRQ_EN  = 3;

  typedef enum logic [1:0] {
    IDLE_REL   = 2'd0,  // button released and settled
    WAIT_PRESS = 2'd1,  // saw a press, waiting for it to stay stable
    IDLE_PRESS = 2'd2,  // button pressed and settled
    WAIT_REL   = 2'd3   // saw a release, waiting for it to stay stable
  } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   Two-flop synchroniser followed by a debounce FSM for an active-low button.
//   A level change is accepted only after the synchronised input has held the
//   new value for DEBOUNCE_CYCLES consecutive cycles; shorter glitches are
//   dropped and the partial count is discarded.
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   raw_n      in   raw button, active-low, asynchronous to clk
//   stable     out  debounced level (1 = released), registered
//   press_evt  out  one-cycle pulse in the cycle whose closing edge flips
//                   stable from 1 to 0; no pulse on release
//   state      out  current debounce FSM state (debug observation)
module button_debouncer
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_n,
  output logic       stable,
  output logic       press_evt,
  output deb_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_d;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          done;

  // The count advances every WAIT cycle; the level flips on the edge where
  // the advanced count reaches DEBOUNCE_CYCLES-1. Together with the two
  // synchroniser stages and the IDLE->WAIT step this puts the flip
  // DEBOUNCE_CYCLES+2 edges after the raw change.
  assign cnt_inc = cnt + 1'b1;
  assign done    = (cnt_inc == CNT_LAST);

  // Decoded from registers only, so the register file sees the event in the
  // same cycle that stable is about to drop.
  assign press_evt = (state == WAIT_PRESS) && !sync_q && done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_d <= 1'b1;
      sync_q <= 1'b1;
      state  <= IDLE_REL;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_d <= raw_n;
      sync_q <= sync_d;
      case (state)
        IDLE_REL: begin
          if (!sync_q) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (sync_q) begin
            state <= IDLE_REL;
          end else if (done) begin
            state  <= IDLE_PRESS;
            stable <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        IDLE_PRESS: begin
          if (sync_q) begin
            state <= WAIT_REL;
            cnt   <= '0;
          end
        end
        WAIT_REL: begin
          if (!sync_q) begin
            state <= IDLE_PRESS;
          end else if (done) begin
            state  <= IDLE_REL;
            stable <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE_REL;
      endcase
    end
  end

endmodule

// File: rtl/button_mmio_port.sv
// button_mmio_port
//   Memory-mapped push-button peripheral on the processor data bus. Debounces
//   the board button, latches presses in a pending flag, counts them in an
//   8-bit wrapping counter with a sticky overflow flag, and exposes this via a
//   2-word register window:
//     +0 STATUS R: {ovf, pressed level, pending}  W: bit0 clears pending,
//                                                    bit2 clears ovf
//     +4 COUNT  R: {24'b0, count}                 W: any store clears count
//   Optional feature macro BTN_IRQ_EN: adds output irq = pending & irq_en,
//   with irq_en at STATUS bit3 (R/W). Without it bit3 reads 0.
// Ports
//   clk, reset (async active-low), button (raw, active-low),
//   addr/mem_write/write_data (data bus), read_data (combinational, 0 outside
//   the window), sel (window hit, drives the top-level read mux),
//   irq (only with BTN_IRQ_EN)
// Bus protocol: mem_write is a single-cycle store strobe qualified by sel and
// acted on at the next rising edge; there is no backpressure and reads are
// purely combinational from addr.
module button_mmio_port
  import io_map_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500_000,
  parameter logic [31:0] BASE_ADDR       = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [31:0] addr,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
`ifdef BTN_IRQ_EN
  output logic        irq,
`endif
  output logic        sel
);

  logic       stable;
  logic       press_evt;
  deb_state_t deb_state;

  logic       pending;
  logic       ovf;
  logic [7:0] count;
  logic       irq_en;

  logic       wr_status;
  logic       wr_count;
  logic       wrap;
  logic [31:0] status_word;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .raw_n     (button),
    .stable    (stable),
    .press_evt (press_evt),
    .state     (deb_state)
  );

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr_status = mem_write && sel && (addr[2] == OFF_STATUS[2]);
  assign wr_count  = mem_write && sel && (addr[2] == OFF_COUNT[2]);

  // A press that lands on a COUNT clear restarts the count at 1 rather than
  // wrapping, so only an unclear increment from 255 counts as overflow.
  assign wrap = press_evt && !wr_count && (count == 8'hFF);

  // Events take priority over software clears landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      ovf     <= 1'b0;
      count   <= 8'h00;
    end else begin
      if (press_evt) begin
        pending <= 1'b1;
      end else if (wr_status && write_data[STAT_PENDING]) begin
        pending <= 1'b0;
      end

      if (press_evt) begin
        count <= wr_count ? 8'h01 : count + 8'h01;
      end else if (wr_count) begin
        count <= 8'h00;
      end

      if (wrap) begin
        ovf <= 1'b1;
      end else if (wr_status && write_data[STAT_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef BTN_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
    end else if (wr_status) begin
      irq_en <= write_data[STAT_IRQ_EN];
    end
  end

  assign irq = pending && irq_en;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    status_word               = 32'h0;
    status_word[STAT_PENDING] = pending;
    status_word[STAT_LEVEL]   = ~stable;
    status_word[STAT_OVF]     = ovf;
    status_word[STAT_IRQ_EN]  = irq_en;
  end

  always_comb begin
    read_data = 32'h0;
    if (sel) begin
      read_data = (addr[2] == OFF_COUNT[2]) ? {24'h0, count} : status_word;
    end
  end

  // Bus bits that no register decodes, plus the debug-only FSM state.
  logic unused_bits;
  assign unused_bits = &{1'b0, addr[1:0], write_data, deb_state};

endmodule
